bht_port_scheduler: RTL and testbench
=====================================

Name: bht_port_scheduler

Overview:
- Owns the single-ported, 1-cycle-read pattern history table (PHT) SRAM used by the gshare predictor.
- Arbitrates that port between decode-stage prediction lookups and execute-stage feedback updates.
- Buffers feedback in a small FIFO and performs each update as a 2-cycle saturating read-modify-write.
- Runs a post-reset init sweep that writes every entry to weakly-not-taken, replacing simulation-only initialisation.

Parameters:
INDEX_BITS, 12, PHT index width; table has 2^INDEX_BITS 2-bit entries
FIFO_DEPTH, 4, feedback FIFO entries (power of two, >=2)
INIT_VALUE, 2'b01, counter value written by the init sweep (WN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  lookup request from decode
req_index  in  INDEX_BITS  lookup index (pc xor ghistory)
req_ready  out  1  lookup accepted this cycle when req_valid && req_ready
rsp_valid  out  1  lookup result valid (1 cycle after acceptance)
rsp_counter  out  2  PHT counter read
rsp_taken  out  1  rsp_counter[1]
fb_valid  in  1  feedback from execute
fb_index  in  INDEX_BITS  feedback index
fb_outcome  in  1  1 = TAKEN
fb_ready  out  1  FIFO can accept feedback this cycle
fb_drop_count  out  8  saturating count of feedback dropped while fb_ready=0
init_done  out  1  init sweep complete
mem_en  out  1  SRAM port enable
mem_we  out  1  SRAM write enable
mem_addr  out  INDEX_BITS  SRAM address
mem_wdata  out  2  SRAM write data
mem_rdata  in  2  SRAM read data, valid cycle after read (mem_en && !mem_we)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset (async): FSM=INIT, init pointer=0, FIFO empty, fb_drop_count=0, init_done=0, req_ready=0, rsp_valid=0, rsp_counter=0, mem_en=0, mem_we=0. Reset mid-sweep or mid-update abandons all work; the sweep restarts from index 0 after rst deasserts.
- FSM states:
  - INIT: each cycle drives mem_en=1, mem_we=1, mem_addr=ptr, mem_wdata=INIT_VALUE, then ptr++. After writing index 2^INDEX_BITS-1, go to IDLE and set init_done=1. The sweep takes exactly 2^INDEX_BITS cycles. req_ready=0 throughout.
  - IDLE, priority order:
    - (a) FIFO full: issue update read of FIFO head (mem_en=1, mem_we=0, mem_addr=head.index), req_ready=0, go to UPD_WR.
    - (b) Otherwise, if req_valid: req_ready=1, read req_index, stay in IDLE.
    - (c) Otherwise, if FIFO non-empty: issue update read of head, go to UPD_WR.
    - (d) Otherwise the port is idle.
  - UPD_WR: write mem_addr=head.index, mem_wdata=sat(mem_rdata, head.outcome), pop FIFO, return to IDLE. req_ready=0.
  - sat: outcome=1 gives min(c+1,3); outcome=0 gives max(c-1,0).
- Lookup latency: rsp_valid=1 exactly one cycle after acceptance, with rsp_counter=mem_rdata. rsp_valid is not asserted for update reads. Back-to-back lookups sustain 1 per cycle while the FIFO is not full.
- Staleness: a lookup is not forwarded from pending FIFO entries and may return a pre-update counter. An update read issued after a prior update write sees the written value, so there is no RAW hazard between updates.
- FIFO:
  - Push when fb_valid && fb_ready.
  - fb_ready = (count<FIFO_DEPTH) || pop_this_cycle. Simultaneous push+pop when full is allowed and count is unchanged.
  - fb_ready=1 during INIT; feedback is queued there and drained after init.
  - fb_valid && !fb_ready drops the feedback and increments fb_drop_count, saturating at 255.
  - Pointers wrap modulo FIFO_DEPTH.
- Starvation bound: a full FIFO blocks lookups for one 2-cycle update per full event.

Test Plan:
- INDEX_BITS=4, rst pulse mid-sweep at cycle 7 -> sweep restarts at addr 0. init_done rises exactly 16 cycles after rst deasserts; a subsequent lookup of every index returns rsp_counter=2'b01.
- After init, req_valid held with indices 3,5,9 on consecutive cycles, FIFO empty -> req_ready=1 each cycle; rsp_valid on the 3 following cycles with counter 01 and rsp_taken=0.
- fb (idx 6, taken) x3 with no lookups -> three RMW pairs, 2 cycles each; entry 6 goes 01→10→11→11 (saturates); a lookup of 6 then returns 11 and rsp_taken=1.
- Lookups every cycle while fb (idx 2, not-taken) pushed 4 times -> the FIFO fills, req_ready drops for one UPD read+write, count returns to 3, and entry 2 reads 00 after all drain (saturates at 0).
- FIFO full plus fb_valid in a non-pop cycle -> fb_ready=0 and fb_drop_count increments 0→1. In a pop cycle (UPD_WR) -> accepted and count stays 4.
- fb_valid asserted 5 times during INIT (FIFO_DEPTH=4) -> 4 queued and 1 dropped; all 4 are applied after init_done, before any later fb entries.

Source files
------------

// File: rtl/bht_port_scheduler.sv
// PHT SRAM port owner for the gshare predictor: post-reset init sweep, lookup/update
// arbitration, and a feedback FIFO drained as 2-cycle saturating read-modify-writes.
module bht_port_scheduler #(
    parameter int unsigned INDEX_BITS = 12,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [1:0]  INIT_VALUE = 2'b01
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [INDEX_BITS-1:0] req_index,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_counter,
    output logic                  rsp_taken,
    input  logic                  fb_valid,
    input  logic [INDEX_BITS-1:0] fb_index,
    input  logic                  fb_outcome,
    output logic                  fb_ready,
    output logic [7:0]            fb_drop_count,
    output logic                  init_done,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [INDEX_BITS-1:0] mem_addr,
    output logic [1:0]            mem_wdata,
    input  logic [1:0]            mem_rdata
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_UPD_WR} state_e;

    typedef struct packed {
        logic [INDEX_BITS-1:0] index;
        logic                  outcome;
    } fb_entry_t;

    state_e                state_q, state_d;
    logic [INDEX_BITS-1:0] ptr_q, ptr_d;
    fb_entry_t             fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [7:0]            drop_q;
    logic                  init_done_q;
    logic                  rsp_valid_q;

    fb_entry_t             head;
    logic                  fifo_full, fifo_empty;
    logic                  push, pop, drop, accept;
    logic                  en_c, we_c, rdy_c;
    logic [INDEX_BITS-1:0] addr_c;
    logic [1:0]            wdata_c;

    function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'b01;
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    assign head       = fifo_q[rd_ptr_q];
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign fb_ready   = !fifo_full || pop;
    assign push       = fb_valid && fb_ready;
    assign drop       = fb_valid && !fb_ready;

    // Port arbitration: full FIFO > lookup > opportunistic drain.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        en_c    = 1'b0;
        we_c    = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        rdy_c   = 1'b0;
        pop     = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                en_c    = 1'b1;
                we_c    = 1'b1;
                addr_c  = ptr_q;
                wdata_c = INIT_VALUE;
                ptr_d   = ptr_q + INDEX_BITS'(1);
                if (&ptr_q) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (fifo_full) begin
                    en_c    = 1'b1;
                    addr_c  = head.index;
                    state_d = ST_UPD_WR;
                end else if (req_valid) begin
                    rdy_c  = 1'b1;
                    en_c   = 1'b1;
                    addr_c = req_index;
                    accept = 1'b1;
                end else if (!fifo_empty) begin
                    en_c    = 1'b1;
                    addr_c  = head.index;
                    state_d = ST_UPD_WR;
                end
            end
            ST_UPD_WR: begin
                en_c    = 1'b1;
                we_c    = 1'b1;
                addr_c  = head.index;
                wdata_c = sat2(mem_rdata, head.outcome);
                pop     = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // SRAM port must see the address in the same cycle; gated so reset holds it quiet.
    assign mem_en    = en_c && !rst;
    assign mem_we    = we_c && !rst;
    assign mem_addr  = addr_c;
    assign mem_wdata = wdata_c;
    assign req_ready = rdy_c && !rst;

    assign rsp_valid     = rsp_valid_q;
    assign rsp_counter   = rsp_valid_q ? mem_rdata : 2'b00;
    assign rsp_taken     = rsp_counter[1];
    assign init_done     = init_done_q;
    assign fb_drop_count = drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            ptr_q       <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= accept;
            if (state_q == ST_INIT && (&ptr_q)) init_done_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= '{index: fb_index, outcome: fb_outcome};
    end

endmodule

// File: tb/tb_bht_port_scheduler.sv
// Directed bench for bht_port_scheduler with a transaction-level model of the
// PHT contents and feedback queue checked against the SRAM port every cycle.
module tb_bht_port_scheduler;
    localparam int unsigned IB      = 4;
    localparam int unsigned ENTRIES = 16;
    localparam int unsigned DEPTH   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic [IB-1:0] req_index;
    logic          req_ready;
    logic          rsp_valid;
    logic [1:0]    rsp_counter;
    logic          rsp_taken;
    logic          fb_valid;
    logic [IB-1:0] fb_index;
    logic          fb_outcome;
    logic          fb_ready;
    logic [7:0]    fb_drop_count;
    logic          init_done;
    logic          mem_en;
    logic          mem_we;
    logic [IB-1:0] mem_addr;
    logic [1:0]    mem_wdata;
    logic [1:0]    mem_rdata;

    int tests = 0;
    int fails = 0;

    bht_port_scheduler #(.INDEX_BITS(IB), .FIFO_DEPTH(DEPTH), .INIT_VALUE(2'b01)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_index(req_index), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_counter(rsp_counter), .rsp_taken(rsp_taken),
        .fb_valid(fb_valid), .fb_index(fb_index), .fb_outcome(fb_outcome),
        .fb_ready(fb_ready), .fb_drop_count(fb_drop_count), .init_done(init_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port SRAM, read data one cycle after a read.
    logic [1:0] sram [ENTRIES];
    logic [1:0] sram_rd;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        sram_rd <= sram[mem_addr];
        end
    end
    assign mem_rdata = sram_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: table contents implied by completed writes, pending feedback queue.
    typedef struct packed {
        logic [IB-1:0] idx;
        logic          taken;
    } fbm_t;

    fbm_t       mq [$];
    logic [1:0] mtbl [ENTRIES];
    int         m_init_cnt = 0;
    bit         m_upd = 0;
    bit         m_acc_prev = 0;
    logic [1:0] m_rsp = 2'b00;
    int         m_drops = 0;

    function automatic logic [1:0] bump(input logic [1:0] c, input logic up);
        int v;
        v = int'(c) + (up ? 1 : -1);
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        return 2'(v);
    endfunction

    always @(negedge clk) begin
        logic          ex_en, ex_we, ex_rr, ex_pop, ex_acc, nx_upd, ex_fbr;
        logic [IB-1:0] ex_addr;
        logic [1:0]    ex_wd;
        if (rst) begin
            chk("rst_mem_en", 32'(mem_en), 32'(0));
            chk("rst_init_done", 32'(init_done), 32'(0));
            chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
            chk("rst_rsp_counter", 32'(rsp_counter), 32'(0));
            chk("rst_req_ready", 32'(req_ready), 32'(0));
            chk("rst_drop_count", 32'(fb_drop_count), 32'(0));
            mq.delete();
            m_init_cnt = 0;
            m_upd      = 0;
            m_acc_prev = 0;
            m_drops    = 0;
        end else begin
            ex_en = 0; ex_we = 0; ex_rr = 0; ex_pop = 0; ex_acc = 0; nx_upd = 0;
            ex_addr = '0; ex_wd = '0;
            if (m_init_cnt < int'(ENTRIES)) begin
                ex_en = 1; ex_we = 1; ex_addr = IB'(m_init_cnt); ex_wd = 2'b01;
            end else if (m_upd && mq.size() > 0) begin
                ex_en = 1; ex_we = 1; ex_addr = mq[0].idx;
                ex_wd = bump(mtbl[mq[0].idx], mq[0].taken); ex_pop = 1;
            end else if (mq.size() == DEPTH) begin
                ex_en = 1; ex_addr = mq[0].idx; nx_upd = 1;
            end else if (req_valid) begin
                ex_en = 1; ex_rr = 1; ex_addr = req_index; ex_acc = 1;
            end else if (mq.size() > 0) begin
                ex_en = 1; ex_addr = mq[0].idx; nx_upd = 1;
            end
            ex_fbr = (mq.size() < DEPTH) || ex_pop;

            chk("mem_en", 32'(mem_en), 32'(ex_en));
            if (ex_en) begin
                chk("mem_we", 32'(mem_we), 32'(ex_we));
                chk("mem_addr", 32'(mem_addr), 32'(ex_addr));
                if (ex_we) chk("mem_wdata", 32'(mem_wdata), 32'(ex_wd));
            end
            if (req_valid) chk("req_ready", 32'(req_ready), 32'(ex_rr));
            chk("fb_ready", 32'(fb_ready), 32'(ex_fbr));
            chk("fb_drop_count", 32'(fb_drop_count), 32'(m_drops));
            chk("init_done", 32'(init_done), 32'(m_init_cnt >= int'(ENTRIES)));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_acc_prev));
            if (m_acc_prev) begin
                chk("rsp_counter", 32'(rsp_counter), 32'(m_rsp));
                chk("rsp_taken", 32'(rsp_taken), 32'(m_rsp[1]));
            end

            if (m_init_cnt < int'(ENTRIES)) begin
                mtbl[m_init_cnt] = 2'b01;
                m_init_cnt++;
            end
            if (ex_acc) m_rsp = mtbl[req_index];
            if (ex_pop) begin
                mtbl[mq[0].idx] = ex_wd;
                void'(mq.pop_front());
            end
            if (fb_valid) begin
                if (ex_fbr) mq.push_back(fbm_t'{fb_index, fb_outcome});
                else if (m_drops < 255) m_drops++;
            end
            m_upd      = nx_upd;
            m_acc_prev = ex_acc;
        end
    end

    task automatic lookup(input logic [IB-1:0] idx, output logic [1:0] cnt, output logic tk);
        int n = 0;
        req_valid = 1; req_index = idx; #1;
        while (!req_ready && n < 50) begin @(posedge clk); #2; n++; end
        chk("lookup_accept", 32'(req_ready), 32'(1));
        @(posedge clk); #1; req_valid = 0; #1;
        chk("lookup_rsp_valid", 32'(rsp_valid), 32'(1));
        cnt = rsp_counter; tk = rsp_taken;
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((mq.size() != 0 || m_upd) && n < 100) begin @(posedge clk); #1; n++; end
        chk("drain_within_bound", 32'(n < 100), 32'(1));
    endtask

    logic [IB-1:0] init_fb_idx [5] = '{4'd6, 4'd6, 4'd6, 4'd2, 4'd9};
    logic          init_fb_tk  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [IB-1:0] burst_idx   [3] = '{4'd3, 4'd5, 4'd9};
    logic          exp_rr      [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
    logic          exp_fr      [6] = '{1, 1, 1, 1, 0, 1};

    initial begin
        logic [1:0] c;
        logic       t;
        rst = 0; req_valid = 0; req_index = '0; fb_valid = 0; fb_index = '0; fb_outcome = 0;
        #1 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (7) @(posedge clk);
        #1 rst = 1;
        #1 chk("mid_sweep_rst_mem_en", 32'(mem_en), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst = 0;
        #1 chk("sweep_restart_addr", 32'(mem_addr), 32'(0));
        chk("sweep_restart_we", 32'(mem_we), 32'(1));

        // Five feedbacks during the sweep: four queue, one drops.
        for (int i = 0; i < 5; i++) begin
            fb_valid = 1; fb_index = init_fb_idx[i]; fb_outcome = init_fb_tk[i];
            @(posedge clk); #1;
        end
        fb_valid = 0;
        repeat (10) @(posedge clk);
        #1 chk("init_done_after_15", 32'(init_done), 32'(0));
        @(posedge clk); #1;
        chk("init_done_after_16", 32'(init_done), 32'(1));
        chk("init_drop_count", 32'(fb_drop_count), 32'(1));
        wait_drain();
        lookup(4'd6, c, t);
        chk("entry6_sat_taken", 32'(c), 32'(2'b11));
        chk("entry6_taken_bit", 32'(t), 32'(1));
        lookup(4'd2, c, t);
        chk("entry2_decremented", 32'(c), 32'(2'b00));
        lookup(4'd9, c, t);
        chk("entry9_dropped_untouched", 32'(c), 32'(2'b01));
        lookup(4'd0, c, t);
        chk("entry0_init", 32'(c), 32'(2'b01));
        lookup(4'd15, c, t);
        chk("entry15_init", 32'(c), 32'(2'b01));

        // Back-to-back lookups, one per cycle.
        for (int i = 0; i < 3; i++) begin
            req_valid = 1; req_index = burst_idx[i]; #1;
            chk("burst_req_ready", 32'(req_ready), 32'(1));
            if (i > 0) begin
                chk("burst_rsp_valid", 32'(rsp_valid), 32'(1));
                chk("burst_rsp_counter", 32'(rsp_counter), 32'(2'b01));
                chk("burst_rsp_taken", 32'(rsp_taken), 32'(0));
            end
            @(posedge clk); #1;
        end
        req_valid = 0; #1;
        chk("burst_last_rsp_valid", 32'(rsp_valid), 32'(1));
        chk("burst_last_rsp_counter", 32'(rsp_counter), 32'(2'b01));
        @(posedge clk); #1;

        // Three taken updates to a fresh entry with the port otherwise idle.
        for (int i = 0; i < 3; i++) begin
            fb_valid = 1; fb_index = 4'd10; fb_outcome = 1;
            @(posedge clk); #1;
        end
        fb_valid = 0;
        wait_drain();
        lookup(4'd10, c, t);
        chk("entry10_saturated", 32'(c), 32'(2'b11));
        chk("entry10_taken_bit", 32'(t), 32'(1));

        // Lookups every cycle while the FIFO fills; full event, drop, push-on-pop.
        for (int i = 0; i < 9; i++) begin
            req_valid = 1; req_index = 4'd1;
            fb_valid = (i < 6); fb_index = 4'd12; fb_outcome = 0; #1;
            chk("starve_req_ready", 32'(req_ready), 32'(exp_rr[i]));
            if (i < 6) chk("full_fb_ready", 32'(fb_ready), 32'(exp_fr[i]));
            @(posedge clk); #1;
        end
        req_valid = 0; fb_valid = 0;
        chk("full_drop_count", 32'(fb_drop_count), 32'(2));
        wait_drain();
        lookup(4'd12, c, t);
        chk("entry12_floor", 32'(c), 32'(2'b00));
        lookup(4'd1, c, t);
        chk("entry1_lookups_only", 32'(c), 32'(2'b01));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
